// File: rtl/pc_trace_pkg.sv
// Shared state encoding and default parameters for the PC trace monitor.
package pc_trace_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        HALT    = 2'd2,
        TIMEOUT = 2'd3
    } state_t;

    localparam int DEF_XLEN        = 32;
    localparam int DEF_DEPTH       = 16;
    localparam int DEF_STALL_LIMIT = 4;
    localparam int DEF_MAX_CYCLES  = 1024;

endpackage

// File: rtl/pc_trace_monitor_if.sv
// Trace input, readback and status bundle between a PC source and the monitor.
interface pc_trace_monitor_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 16
);
    localparam int AW = $clog2(DEPTH);

    logic            clear;
    logic            pc_valid;
    logic [XLEN-1:0] pc_in;
    logic [AW-1:0]   rd_addr;
    logic [XLEN-1:0] rd_data;
    logic [AW:0]     count;
    logic [31:0]     cycles;
    logic [1:0]      state;
    logic            done;

    modport master (
        output clear, pc_valid, pc_in, rd_addr,
        input  rd_data, count, cycles, state, done
    );

    modport slave (
        input  clear, pc_valid, pc_in, rd_addr,
        output rd_data, count, cycles, state, done
    );
endinterface

// File: rtl/trace_ring.sv
// Circular PC store: overwrites the oldest entry once full, read index is oldest-relative.
module trace_ring #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clr,
    input  logic                      we,
    input  logic [XLEN-1:0]           wdata,
    input  logic [$clog2(DEPTH)-1:0]  rd_addr,
    output logic [XLEN-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]    count
);
    localparam int AW = $clog2(DEPTH);

    logic [XLEN-1:0] mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW:0]     count_q;
    logic [AW-1:0]   oldest;
    logic [AW-1:0]   idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (clr) begin
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (we) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (count_q != (AW+1)'(DEPTH))
                count_q <= count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we && !clr)
            mem[wr_ptr] <= wdata;
    end

    // When full, count's low bits are zero so the oldest entry sits at wr_ptr.
    always_comb begin
        oldest  = wr_ptr - count_q[AW-1:0];
        idx     = oldest + rd_addr;
        rd_data = ({1'b0, rd_addr} < count_q) ? mem[idx] : '0;
    end

    assign count = count_q;
endmodule

// File: rtl/pc_trace_monitor.sv
// Captures retired PCs into a ring, detects stalls (halt) and cycle-budget overrun (timeout).
module pc_trace_monitor
    import pc_trace_pkg::*;
#(
    parameter int XLEN        = DEF_XLEN,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int STALL_LIMIT = DEF_STALL_LIMIT,
    parameter int MAX_CYCLES  = DEF_MAX_CYCLES
) (
    input logic               clk,
    input logic               reset,
    pc_trace_monitor_if.slave bus
);
    localparam int SW = $clog2(STALL_LIMIT + 1);

    state_t          state_q;
    state_t          state_d;
    logic [31:0]     cycles_q;
    logic [SW-1:0]   run_q;
    logic [XLEN-1:0] last_pc;
    logic            capture;
    logic            same_pc;
    logic            stall_hit;
    logic            budget_hit;

    always_comb begin
        capture    = bus.pc_valid && !bus.clear && (state_q == IDLE || state_q == RUN);
        same_pc    = (state_q == RUN) && (bus.pc_in == last_pc);
        stall_hit  = capture && same_pc && (run_q == SW'(STALL_LIMIT - 1));
        budget_hit = (state_q == RUN) && (cycles_q == 32'(MAX_CYCLES - 1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // A stall landing on the last budgeted cycle reports HALT, not TIMEOUT.
    always_comb begin
        state_d = state_q;
        if (bus.clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (capture) state_d = RUN;
                RUN: begin
                    if (stall_hit)
                        state_d = HALT;
                    else if (budget_hit)
                        state_d = TIMEOUT;
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycles_q <= '0;
            run_q    <= '0;
        end else if (bus.clear) begin
            cycles_q <= '0;
            run_q    <= '0;
        end else begin
            if (state_q == RUN)
                cycles_q <= cycles_q + 1'b1;
            if (capture)
                run_q <= same_pc ? SW'(run_q + 1'b1) : SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (capture)
            last_pc <= bus.pc_in;
    end

    trace_ring #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_ring (
        .clk     (clk),
        .reset   (reset),
        .clr     (bus.clear),
        .we      (capture),
        .wdata   (bus.pc_in),
        .rd_addr (bus.rd_addr),
        .rd_data (bus.rd_data),
        .count   (bus.count)
    );

    assign bus.state  = state_q;
    assign bus.cycles = cycles_q;
    assign bus.done   = (state_q == HALT) || (state_q == TIMEOUT);
endmodule
